// File: rtl/tictactoe_pkg.sv
// Shared tic-tac-toe definitions: engine status codes, grid squares and
// the move-arbiter state encoding.
`timescale 1ns/1ps
package tictactoe_pkg;

  localparam logic [7:0] ASCII_NONE = 8'h6E;  // 'n' game in progress
  localparam logic [7:0] ASCII_ERR  = 8'h45;  // 'E' square occupied
  localparam logic [7:0] ASCII_XWIN = 8'h58;  // 'X'
  localparam logic [7:0] ASCII_OWIN = 8'h4F;  // 'O'
  localparam logic [7:0] ASCII_CATS = 8'h43;  // 'C'

  localparam int GRID_N = 9;

  // Grid bit 8 is top-left, bit 0 is bottom-right, row-major.
  localparam logic [GRID_N-1:0] SQ_TL = 9'h100;
  localparam logic [GRID_N-1:0] SQ_TC = 9'h080;
  localparam logic [GRID_N-1:0] SQ_TR = 9'h040;
  localparam logic [GRID_N-1:0] SQ_ML = 9'h020;
  localparam logic [GRID_N-1:0] SQ_MC = 9'h010;
  localparam logic [GRID_N-1:0] SQ_MR = 9'h008;
  localparam logic [GRID_N-1:0] SQ_BL = 9'h004;
  localparam logic [GRID_N-1:0] SQ_BC = 9'h002;
  localparam logic [GRID_N-1:0] SQ_BR = 9'h001;

  localparam int               TALLY_W   = 4;
  localparam logic [TALLY_W-1:0] TALLY_MAX = 4'hF;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_TURN,
    ISSUE,
    HOLD,
    RESULT,
    GAME_OVER,
    MATCH_END
  } arb_state_e;

endpackage

// File: rtl/onehot9_check.sv
// Flags a grid selection that names exactly one square.
`timescale 1ns/1ps
module onehot9_check
  import tictactoe_pkg::*;
(
  input  logic [GRID_N-1:0] vec,
  output logic              onehot
);

  assign onehot = (vec != '0) && ((vec & (vec - 1'b1)) == '0);

endmodule

// File: rtl/tictactoe_move_arbiter.sv
// Serialises X/O move requests into engine strobes, tracks results and
// keeps the match tallies.
`timescale 1ns/1ps
module tictactoe_move_arbiter
  import tictactoe_pkg::*;
#(
  parameter int WINS_TO_MATCH = 3,
  parameter int PAUSE_CYC     = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                reqX,
  input  logic                reqO,
  input  logic [GRID_N-1:0]   posX,
  input  logic [GRID_N-1:0]   posO,
  input  logic                turnX,
  input  logic                turnO,
  input  logic [7:0]          game_st_ascii,
  output logic [GRID_N-1:0]   sel_pos,
  output logic                buttonX,
  output logic                buttonO,
  output logic                game_reset,
  output logic                ackX,
  output logic                ackO,
  output logic                nackX,
  output logic                nackO,
  output logic [TALLY_W-1:0]  scoreX,
  output logic [TALLY_W-1:0]  scoreO,
  output logic [TALLY_W-1:0]  cats,
  output logic                match_done
);

  localparam int                PW         = (PAUSE_CYC > 1) ? $clog2(PAUSE_CYC) : 1;
  localparam logic [PW-1:0]     PAUSE_LAST = PW'(PAUSE_CYC - 1);
  localparam logic [TALLY_W-1:0] WIN_CNT   = TALLY_W'(WINS_TO_MATCH);

  function automatic logic [TALLY_W-1:0] sat_inc(input logic [TALLY_W-1:0] v);
    return (v == TALLY_MAX) ? v : v + 1'b1;
  endfunction

  arb_state_e          state_q, state_d;
  logic [GRID_N-1:0]   sel_q, sel_d;
  logic                srv_x_q, srv_x_d;
  logic                hold_q, hold_d;
  logic [PW-1:0]       pause_q, pause_d;
  logic [TALLY_W-1:0]  scx_q, scx_d, sco_q, sco_d, cats_q, cats_d;

  logic                serve_x, serve_o, pos_ok;
  logic [GRID_N-1:0]   srv_pos;
  logic                btnx_c, btno_c, ackx_c, acko_c, nackx_c, nacko_c, gr_c, done_c;

  // The turn owner wins any tie; the other side simply stays pending.
  assign serve_x = turnX & reqX;
  assign serve_o = ~turnX & turnO & reqO;
  assign srv_pos = serve_x ? posX : posO;

  onehot9_check u_onehot (
    .vec    (srv_pos),
    .onehot (pos_ok)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      hold_q  <= 1'b0;
      pause_q <= '0;
      scx_q   <= '0;
      sco_q   <= '0;
      cats_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      pause_q <= pause_d;
      scx_q   <= scx_d;
      sco_q   <= sco_d;
      cats_q  <= cats_d;
    end
  end

  always_ff @(posedge clk) begin
    sel_q   <= sel_d;
    srv_x_q <= srv_x_d;
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    srv_x_d = srv_x_q;
    hold_d  = hold_q;
    pause_d = pause_q;
    scx_d   = scx_q;
    sco_d   = sco_q;
    cats_d  = cats_q;
    btnx_c  = 1'b0;
    btno_c  = 1'b0;
    ackx_c  = 1'b0;
    acko_c  = 1'b0;
    nackx_c = 1'b0;
    nacko_c = 1'b0;
    gr_c    = 1'b0;
    done_c  = 1'b0;
    case (state_q)
      IDLE: begin
        gr_c    = 1'b1;
        state_d = WAIT_TURN;
      end
      WAIT_TURN: begin
        if (serve_x || serve_o) begin
          if (!pos_ok) begin
            nackx_c = serve_x;
            nacko_c = serve_o;
          end else begin
            sel_d   = srv_pos;
            srv_x_d = serve_x;
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        btnx_c  = srv_x_q;
        btno_c  = ~srv_x_q;
        hold_d  = 1'b0;
        state_d = HOLD;
      end
      HOLD: begin
        if (hold_q) state_d = RESULT;
        else        hold_d  = 1'b1;
      end
      RESULT: begin
        ackx_c  = srv_x_q;
        acko_c  = ~srv_x_q;
        pause_d = '0;
        state_d = GAME_OVER;
        case (game_st_ascii)
          ASCII_NONE: state_d = WAIT_TURN;
          ASCII_XWIN: scx_d   = sat_inc(scx_q);
          ASCII_OWIN: sco_d   = sat_inc(sco_q);
          ASCII_CATS: cats_d  = sat_inc(cats_q);
          default: begin
            ackx_c  = 1'b0;
            acko_c  = 1'b0;
            nackx_c = srv_x_q;
            nacko_c = ~srv_x_q;
            state_d = WAIT_TURN;
          end
        endcase
      end
      GAME_OVER: begin
        if (pause_q == PAUSE_LAST)
          state_d = ((scx_q == WIN_CNT) || (sco_q == WIN_CNT)) ? MATCH_END : IDLE;
        else
          pause_d = pause_q + 1'b1;
      end
      MATCH_END: done_c = 1'b1;
      default:   state_d = IDLE;
    endcase
  end

  // Reset overrides every output combinationally, not just from the next edge.
  assign sel_pos    = (!reset && (state_q == ISSUE || state_q == HOLD || state_q == RESULT))
                      ? sel_q : '0;
  assign buttonX    = ~reset & btnx_c;
  assign buttonO    = ~reset & btno_c;
  assign ackX       = ~reset & ackx_c;
  assign ackO       = ~reset & acko_c;
  assign nackX      = ~reset & nackx_c;
  assign nackO      = ~reset & nacko_c;
  assign game_reset = reset | gr_c;
  assign match_done = ~reset & done_c;
  assign scoreX     = reset ? '0 : scx_q;
  assign scoreO     = reset ? '0 : sco_q;
  assign cats       = reset ? '0 : cats_q;

endmodule

// File: tb/tb_tictactoe_move_arbiter.sv
// Scoreboard bench for tictactoe_move_arbiter: the bench plays the engine.
`timescale 1ns/1ps
module tb_tictactoe_move_arbiter;
  import tictactoe_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       reqX = 1'b0, reqO = 1'b0;
  logic [8:0] posX = '0, posO = '0;
  logic       turnX = 1'b0, turnO = 1'b0;
  logic [7:0] game_st_ascii = ASCII_NONE;
  logic [8:0] sel_pos;
  logic       buttonX, buttonO, game_reset, ackX, ackO, nackX, nackO, match_done;
  logic [3:0] scoreX, scoreO, cats;

  tictactoe_move_arbiter #(.WINS_TO_MATCH(3), .PAUSE_CYC(4)) dut (
    .clk(clk), .reset(reset), .reqX(reqX), .reqO(reqO), .posX(posX), .posO(posO),
    .turnX(turnX), .turnO(turnO), .game_st_ascii(game_st_ascii), .sel_pos(sel_pos),
    .buttonX(buttonX), .buttonO(buttonO), .game_reset(game_reset), .ackX(ackX), .ackO(ackO),
    .nackX(nackX), .nackO(nackO), .scoreX(scoreX), .scoreO(scoreO), .cats(cats),
    .match_done(match_done)
  );

  always #5 clk = ~clk;

  localparam logic [5:0] EV_BX = 6'b100000, EV_BO = 6'b010000, EV_AX = 6'b001000,
                         EV_AO = 6'b000100, EV_NX = 6'b000010, EV_NO = 6'b000001;

  int          n_chk = 0, n_fail = 0;
  logic [14:0] expq[$];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Every strobe/ack/nack must match the next queued expectation.
  always @(negedge clk) begin
    if ({buttonX, buttonO, ackX, ackO, nackX, nackO} != 6'd0) begin
      if (expq.size() == 0)
        check("unexpected_event", {17'd0, buttonX, buttonO, ackX, ackO, nackX, nackO, sel_pos}, 32'd0);
      else
        check("event", {17'd0, buttonX, buttonO, ackX, ackO, nackX, nackO, sel_pos},
              {17'd0, expq.pop_front()});
    end
  end

  // kind: 0 = rejected as malformed, 1 = acked at result, 2 = nacked at result
  task automatic move(input bit isx, input logic [8:0] pos, input logic [7:0] code, input int kind);
    int   t_btn, t_done;
    bit   done;
    logic [5:0] res;
    game_st_ascii = code;
    if (kind == 0) begin
      expq.push_back({(isx ? EV_NX : EV_NO), 9'h000});
    end else begin
      res = (kind == 1) ? (isx ? EV_AX : EV_AO) : (isx ? EV_NX : EV_NO);
      expq.push_back({(isx ? EV_BX : EV_BO), pos});
      expq.push_back({res, pos});
    end
    if (isx) begin reqX = 1'b1; posX = pos; end
    else     begin reqO = 1'b1; posO = pos; end
    t_btn = 0; t_done = 0; done = 1'b0;
    for (int n = 1; n <= 20 && !done; n++) begin
      @(negedge clk);
      if (isx ? buttonX : buttonO) t_btn = n;
      else if (t_btn != 0) check("hold_sel", {23'd0, sel_pos}, {23'd0, pos});
      if (isx ? (ackX | nackX) : (ackO | nackO)) begin
        done = 1'b1;
        t_done = n;
      end
    end
    check("move_done", {31'd0, done}, 32'd1);
    if (kind != 0) begin
      check("btn_lat", t_btn, 2);
      check("result_lat", t_done - t_btn, 3);
    end else begin
      check("nack_lat", t_done, 1);
      check("no_btn", t_btn, 0);
    end
    @(posedge clk); #1;
    if (isx) begin reqX = 1'b0; posX = '0; end
    else     begin reqO = 1'b0; posO = '0; end
  endtask

  task automatic wait_gameover(input bit to_match);
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      if (i < 5) check("pause_gr", {31'd0, game_reset}, 32'd0);
      else if (to_match) begin
        check("match_done", {31'd0, match_done}, 32'd1);
        check("match_no_gr", {31'd0, game_reset}, 32'd0);
      end else check("next_game_gr", {31'd0, game_reset}, 32'd1);
    end
    if (!to_match) begin
      @(negedge clk);
      check("gr_one_cycle", {31'd0, game_reset}, 32'd0);
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    reqX = 1'b0; reqO = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("rst_gr", {31'd0, game_reset}, 32'd1);
      check("rst_outs", {4'd0, sel_pos, buttonX, buttonO, ackX, ackO, nackX, nackO,
                         scoreX, scoreO, cats, match_done}, 32'd0);
    end
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk); check("idle_gr", {31'd0, game_reset}, 32'd1);
    @(negedge clk); check("wait_no_gr", {31'd0, game_reset}, 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bit seen;
    do_reset();

    // basic accepted move
    turnX = 1'b1; turnO = 1'b0;
    move(1'b1, SQ_MC, ASCII_NONE, 1);

    // O request while X owns the turn stays pending
    reqO = 1'b1; posO = SQ_BR;
    repeat (4) @(negedge clk);
    check("pending_o", {30'd0, buttonO, nackO}, 32'd0);
    @(posedge clk); #1 turnX = 1'b0; turnO = 1'b1;
    move(1'b0, SQ_BR, ASCII_NONE, 1);

    // malformed, occupied, and unknown-status moves
    turnX = 1'b1; turnO = 1'b0;
    move(1'b1, 9'h011, ASCII_NONE, 0);
    move(1'b1, SQ_MC, ASCII_ERR, 2);
    move(1'b1, SQ_MR, 8'h3F, 2);
    check("no_score_yet", {20'd0, scoreX, scoreO, cats}, 32'd0);

    // X wins; one O move is made while X also requests
    move(1'b1, SQ_TL, ASCII_NONE, 1);
    turnX = 1'b0; turnO = 1'b1;
    move(1'b0, SQ_TC, ASCII_NONE, 1);
    turnX = 1'b1; turnO = 1'b0;
    move(1'b1, SQ_ML, ASCII_NONE, 1);
    turnX = 1'b0; turnO = 1'b1;
    reqX = 1'b1; posX = SQ_BL;
    move(1'b0, SQ_TR, ASCII_NONE, 1);
    turnX = 1'b1; turnO = 1'b0;
    move(1'b1, SQ_BL, ASCII_XWIN, 1);
    check("scoreX_1", {28'd0, scoreX}, 32'd1);
    wait_gameover(1'b0);

    // reset while the move is in HOLD aborts it and clears tallies
    expq.push_back({EV_BX, SQ_MC});
    game_st_ascii = ASCII_NONE;
    reqX = 1'b1; posX = SQ_MC;
    seen = 1'b0;
    for (int n = 0; n < 6 && !seen; n++) begin
      @(negedge clk);
      if (buttonX) seen = 1'b1;
    end
    check("abort_btn_seen", {31'd0, seen}, 32'd1);
    @(posedge clk); #1;
    do_reset();
    check("scores_cleared", {20'd0, scoreX, scoreO, cats}, 32'd0);

    // cats saturate and never end the match
    turnX = 1'b0; turnO = 1'b1;
    for (int g = 0; g < 16; g++) begin
      move(1'b0, SQ_MC, ASCII_CATS, 1);
      wait_gameover(1'b0);
    end
    check("cats_sat", {28'd0, cats}, 32'd15);

    move(1'b0, SQ_TL, ASCII_OWIN, 1);
    wait_gameover(1'b0);
    check("scoreO_1", {28'd0, scoreO}, 32'd1);

    turnX = 1'b1; turnO = 1'b0;
    for (int g = 1; g <= 3; g++) begin
      move(1'b1, SQ_MC, ASCII_XWIN, 1);
      check("scoreX_win", {28'd0, scoreX}, g);
      wait_gameover(g == 3);
    end

    // requests after the match are ignored
    reqX = 1'b1; posX = SQ_BR;
    repeat (6) @(negedge clk);
    check("match_hold", {30'd0, match_done, buttonX}, 32'd2);
    @(posedge clk); #1 reqX = 1'b0;
    @(negedge clk);
    check("queue_empty", expq.size(), 0);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
